// File: rtl/lio_axil2ahb_rr.sv
// rtl/lio_axil2ahb_rr.sv - AXI-Lite slave to AHB master bridge with round-robin write/read arbitration
module lio_axil2ahb_rr #(
    parameter int AWIDTH             = 16,
    parameter int DWIDTH             = 32,
    parameter int SIZE_SEL_ADDR_BITS = 0,
    parameter int TIMEOUT            = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               rst,
    input  logic [AWIDTH+SIZE_SEL_ADDR_BITS-1:0] axil_awaddr,
    input  logic [2:0]                         axil_awprot,
    input  logic                               axil_awvalid,
    output logic                               axil_awready,
    input  logic [DWIDTH-1:0]                  axil_wdata,
    input  logic [DWIDTH/8-1:0]                axil_wstrb,
    input  logic                               axil_wvalid,
    output logic                               axil_wready,
    output logic [1:0]                         axil_bresp,
    output logic                               axil_bvalid,
    input  logic                               axil_bready,
    input  logic [AWIDTH+SIZE_SEL_ADDR_BITS-1:0] axil_araddr,
    input  logic [2:0]                         axil_arprot,
    input  logic                               axil_arvalid,
    output logic                               axil_arready,
    output logic [DWIDTH-1:0]                  axil_rdata,
    output logic [1:0]                         axil_rresp,
    output logic                               axil_rvalid,
    input  logic                               axil_rready,
    output logic [AWIDTH-1:0]                  haddr,
    output logic [DWIDTH-1:0]                  hwdata,
    output logic                               hsel,
    output logic                               hwrite,
    output logic [1:0]                         htrans,
    output logic [2:0]                         hsize,
    input  logic                               hready,
    input  logic [DWIDTH-1:0]                  hrdata,
    input  logic [1:0]                         hresp
);
    localparam int NB  = DWIDTH / 8;
    localparam int LOG = $clog2(NB);
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t state, state_n;

    logic              aw_full, w_full, is_wr, last_wr;
    logic [AWIDTH-1:0] aw_addr;
    logic [DWIDTH-1:0] w_data;
    logic [NB-1:0]     w_strb;
    logic [1:0]        resp_q;
    logic [CW-1:0]     cnt;
    logic              grant_wr, grant_rd, timeout_hit;
    logic              strb_ok;
    logic [2:0]        strb_size, rd_size;
    logic [LOG-1:0]    strb_off;
    logic [NB-1:0]     mask;
    logic [AWIDTH-1:0] wr_haddr;
    logic              unused;

    assign rst          = ~rst_n;
    assign axil_awready = (state == IDLE) && !aw_full;
    assign axil_wready  = (state == IDLE) && !w_full;
    assign axil_bresp   = resp_q;
    assign axil_rresp   = resp_q;
    assign hwdata       = (state == DATA && is_wr) ? w_data : '0;
    assign unused       = ^{axil_awprot, axil_arprot, hresp[1], axil_awaddr, axil_araddr};

    // Only full-width or naturally aligned contiguous 1/2/4-byte strobe groups map to one AHB beat.
    always_comb begin
        strb_ok   = 1'b0;
        strb_size = 3'(LOG);
        strb_off  = '0;
        mask      = '0;
        if (w_strb == '1) begin
            strb_ok = 1'b1;
        end else begin
            for (int s = 0; s < LOG; s++) begin
                for (int o = 0; o < NB; o += (1 << s)) begin
                    mask = '0;
                    for (int b = 0; b < (1 << s); b++) mask[o+b] = 1'b1;
                    if (w_strb == mask) begin
                        strb_ok   = 1'b1;
                        strb_size = 3'(s);
                        strb_off  = o[LOG-1:0];
                    end
                end
            end
        end
        wr_haddr = strb_ok ? {aw_addr[AWIDTH-1:LOG], strb_off} : aw_addr;
    end

    generate
        if (SIZE_SEL_ADDR_BITS == 0) begin : g_nowin
            assign rd_size = 3'(LOG);
        end else begin : g_win
            logic [SIZE_SEL_ADDR_BITS-1:0] win;
            assign win     = axil_araddr[AWIDTH+SIZE_SEL_ADDR_BITS-1:AWIDTH];
            assign rd_size = (int'(win) <= LOG) ? 3'(win) : 3'(LOG);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n      = state;
        grant_wr     = 1'b0;
        grant_rd     = 1'b0;
        axil_arready = 1'b0;
        hsel         = 1'b0;
        htrans       = 2'b00;
        hwrite       = 1'b0;
        timeout_hit  = (TIMEOUT != 0) && !hready && (cnt == CW'(TIMEOUT - 1));
        case (state)
            IDLE: begin
                if (aw_full && w_full && (!axil_arvalid || !last_wr)) begin
                    grant_wr = 1'b1;
                    state_n  = strb_ok ? ADDR : RESP;
                end else if (axil_arvalid) begin
                    grant_rd     = 1'b1;
                    axil_arready = 1'b1;
                    state_n      = ADDR;
                end
            end
            ADDR: begin
                hsel   = 1'b1;
                htrans = 2'b10;
                hwrite = is_wr;
                if (hready)           state_n = DATA;
                else if (timeout_hit) state_n = RESP;
            end
            DATA: if (hready || timeout_hit) state_n = RESP;
            RESP: if ((axil_bvalid && axil_bready) || (axil_rvalid && axil_rready)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            aw_addr     <= '0;
            w_strb      <= '0;
            is_wr       <= 1'b0;
            last_wr     <= 1'b0;
            haddr       <= '0;
            hsize       <= 3'(LOG);
            resp_q      <= 2'b00;
            axil_bvalid <= 1'b0;
            axil_rvalid <= 1'b0;
            cnt         <= '0;
        end else begin
            if (axil_awvalid && axil_awready) begin
                aw_full <= 1'b1;
                aw_addr <= axil_awaddr[AWIDTH-1:0];
            end
            if (axil_wvalid && axil_wready) begin
                w_full <= 1'b1;
                w_strb <= axil_wstrb;
            end
            if (grant_wr) begin
                is_wr   <= 1'b1;
                last_wr <= 1'b1;
                haddr   <= wr_haddr;
                hsize   <= strb_ok ? strb_size : 3'(LOG);
                if (!strb_ok) begin
                    resp_q      <= 2'b10;
                    axil_bvalid <= 1'b1;
                end
            end
            if (grant_rd) begin
                is_wr   <= 1'b0;
                last_wr <= 1'b0;
                haddr   <= axil_araddr[AWIDTH-1:0];
                hsize   <= rd_size;
            end
            if ((state == ADDR || state == DATA) && state_n == RESP) begin
                resp_q <= timeout_hit ? 2'b11 : (hresp[0] ? 2'b10 : 2'b00);
                if (is_wr) axil_bvalid <= 1'b1;
                else       axil_rvalid <= 1'b1;
            end
            if (axil_bvalid && axil_bready) begin
                axil_bvalid <= 1'b0;
                aw_full     <= 1'b0;
                w_full      <= 1'b0;
            end
            if (axil_rvalid && axil_rready) axil_rvalid <= 1'b0;
            if (state_n != state)                                 cnt <= '0;
            else if ((state == ADDR || state == DATA) && !hready) cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (axil_wvalid && axil_wready)           w_data     <= axil_wdata;
        if (state == DATA && hready && !is_wr)    axil_rdata <= hrdata;
    end
endmodule

// File: tb/tb_lio_axil2ahb_rr.sv
// tb/tb_lio_axil2ahb_rr.sv - scoreboard bench for lio_axil2ahb_rr
module tb_lio_axil2ahb_rr;
    logic        clk = 1'b0;
    logic        rst_n, rst;
    logic [15:0] axil_awaddr, axil_araddr;
    logic [2:0]  axil_awprot, axil_arprot;
    logic        axil_awvalid, axil_awready, axil_wvalid, axil_wready;
    logic [31:0] axil_wdata, axil_rdata;
    logic [3:0]  axil_wstrb;
    logic [1:0]  axil_bresp, axil_rresp;
    logic        axil_bvalid, axil_bready, axil_arvalid, axil_arready, axil_rvalid, axil_rready;
    logic [15:0] haddr;
    logic [31:0] hwdata, hrdata;
    logic        hsel, hwrite, hready;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {logic wr; logic [15:0] addr; logic [2:0] size; logic [31:0] wdata;} xfer_t;
    typedef struct {logic wr; logic [1:0] resp; logic chk_data; logic [31:0] rdata;} rsp_t;
    xfer_t ahb_q[$];
    rsp_t  rsp_q[$];

    always #5 clk = ~clk;

    lio_axil2ahb_rr #(.AWIDTH(16), .DWIDTH(32), .SIZE_SEL_ADDR_BITS(0), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .rst(rst),
        .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot), .axil_awvalid(axil_awvalid),
        .axil_awready(axil_awready), .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
        .axil_wvalid(axil_wvalid), .axil_wready(axil_wready), .axil_bresp(axil_bresp),
        .axil_bvalid(axil_bvalid), .axil_bready(axil_bready), .axil_araddr(axil_araddr),
        .axil_arprot(axil_arprot), .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
        .axil_rdata(axil_rdata), .axil_rresp(axil_rresp), .axil_rvalid(axil_rvalid),
        .axil_rready(axil_rready), .haddr(haddr), .hwdata(hwdata), .hsel(hsel),
        .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hready(hready),
        .hrdata(hrdata), .hresp(hresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AHB slave: read data encodes the address accepted in the last read address phase
    logic [15:0] rd_addr;
    always @(posedge clk) if (hsel && hready && htrans == 2'b10 && !hwrite) rd_addr <= haddr;
    assign hrdata = {16'hC0DE, rd_addr};

    logic        dp_active = 1'b0;
    logic [31:0] dp_wdata;
    always @(negedge clk) begin
        if (!rst_n) begin
            dp_active = 1'b0;
        end else begin
            if (dp_active && hready) begin
                chk("hwdata", hwdata, dp_wdata);
                dp_active = 1'b0;
            end
            if (hsel && htrans == 2'b10 && hready) begin
                chk("xfer_expected", ahb_q.size() > 0, 1'b1);
                if (ahb_q.size() > 0) begin
                    xfer_t e;
                    e = ahb_q.pop_front();
                    chk("hwrite", hwrite, e.wr);
                    chk("haddr", haddr, e.addr);
                    chk("hsize", hsize, e.size);
                    if (e.wr) begin
                        dp_active = 1'b1;
                        dp_wdata  = e.wdata;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ((axil_bvalid && axil_bready) || (axil_rvalid && axil_rready))) begin
            chk("rsp_expected", rsp_q.size() > 0, 1'b1);
            if (rsp_q.size() > 0) begin
                rsp_t e;
                e = rsp_q.pop_front();
                chk("rsp_dir_write", axil_bvalid, e.wr);
                if (axil_bvalid) chk("bresp", axil_bresp, e.resp);
                else             chk("rresp", axil_rresp, e.resp);
                if (axil_rvalid && e.chk_data) chk("rdata", axil_rdata, e.rdata);
            end
        end
    end

    task automatic exp_x(input logic wr, input logic [15:0] a, input logic [2:0] sz, input logic [31:0] d);
        ahb_q.push_back('{wr, a, sz, d});
    endtask

    task automatic exp_r(input logic wr, input logic [1:0] r, input logic cd, input logic [31:0] d);
        rsp_q.push_back('{wr, r, cd, d});
    endtask

    task automatic send_aw(input logic [15:0] a);
        axil_awaddr  = a;
        axil_awvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (axil_awready) break;
        end
        chk("aw_handshake", axil_awready, 1'b1);
        @(posedge clk); #1 axil_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        axil_wdata  = d;
        axil_wstrb  = s;
        axil_wvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (axil_wready) break;
        end
        chk("w_handshake", axil_wready, 1'b1);
        @(posedge clk); #1 axil_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] a);
        axil_araddr  = a;
        axil_arvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (axil_arready) break;
        end
        chk("ar_handshake", axil_arready, 1'b1);
        @(posedge clk); #1 axil_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (ahb_q.size() == 0 && rsp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", ahb_q.size() + rsp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsel"}, hsel, 1'b0);
        chk({tag, "_htrans"}, htrans, 2'b00);
        chk({tag, "_hwrite"}, hwrite, 1'b0);
        chk({tag, "_haddr"}, haddr, 16'h0);
        chk({tag, "_hsize"}, hsize, 3'd2);
        chk({tag, "_bvalid"}, axil_bvalid, 1'b0);
        chk({tag, "_rvalid"}, axil_rvalid, 1'b0);
        chk({tag, "_bresp"}, axil_bresp, 2'b00);
        chk({tag, "_rresp"}, axil_rresp, 2'b00);
        chk({tag, "_rst"}, rst, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  strbs [6];
        logic        hits  [6];
        logic [15:0] addrs [6];
        logic [2:0]  sizes [6];
        int          cyc;
        logic        any_valid;

        rst_n = 1'b0;
        axil_awaddr = '0; axil_awprot = '0; axil_awvalid = 1'b0;
        axil_wdata = '0; axil_wstrb = '0; axil_wvalid = 1'b0; axil_bready = 1'b1;
        axil_araddr = '0; axil_arprot = '0; axil_arvalid = 1'b0; axil_rready = 1'b1;
        hready = 1'b1; hresp = 2'b00;

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("rst_released", rst, 1'b0);
        chk("awready_idle", axil_awready, 1'b1);
        chk("wready_idle", axil_wready, 1'b1);
        chk("arready_idle", axil_arready, 1'b0);

        // write and read both pending: round-robin W,R,W,R with write first after reset
        exp_x(1'b1, 16'h0200, 3'd2, 32'h1111_0000);
        exp_x(1'b0, 16'h0300, 3'd2, 32'h0);
        exp_x(1'b1, 16'h0204, 3'd2, 32'h2222_0000);
        exp_x(1'b0, 16'h0304, 3'd2, 32'h0);
        exp_r(1'b1, 2'b00, 1'b0, 32'h0);
        exp_r(1'b0, 2'b00, 1'b1, 32'hC0DE_0300);
        exp_r(1'b1, 2'b00, 1'b0, 32'h0);
        exp_r(1'b0, 2'b00, 1'b1, 32'hC0DE_0304);
        fork
            begin
                do_write(16'h0200, 32'h1111_0000, 4'hF);
                do_write(16'h0204, 32'h2222_0000, 4'hF);
            end
            begin
                @(posedge clk); #1;
                send_ar(16'h0300);
                send_ar(16'h0304);
            end
        join
        drain();

        // W two cycles ahead of AW
        exp_x(1'b1, 16'h0040, 3'd2, 32'hA5A5_1234);
        exp_r(1'b1, 2'b00, 1'b0, 32'h0);
        fork
            send_w(32'hA5A5_1234, 4'hF);
            begin
                repeat (2) @(posedge clk); #1;
                send_aw(16'h0040);
            end
        join
        drain();

        // strobe decode table
        strbs = '{4'h4, 4'hC, 4'h3, 4'h5, 4'h0, 4'h6};
        hits  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        addrs = '{16'h0102, 16'h0102, 16'h0100, 16'h0, 16'h0, 16'h0};
        sizes = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 6; i++) begin
            if (hits[i]) exp_x(1'b1, addrs[i], sizes[i], 32'hCAFE_0000 + 32'(i));
            exp_r(1'b1, hits[i] ? 2'b00 : 2'b10, 1'b0, 32'h0);
            do_write(16'h0100 + 16'(i == 2), 32'hCAFE_0000 + 32'(i), strbs[i]);
            drain();
        end

        // read with DATA stall, SLVERR, rdata held while rready low
        exp_x(1'b0, 16'h0010, 3'd2, 32'h0);
        exp_r(1'b0, 2'b10, 1'b1, 32'hC0DE_0010);
        axil_rready = 1'b0;
        send_ar(16'h0010);
        @(posedge clk); #1 hready = 1'b0;
        repeat (3) @(posedge clk);
        #1 hready = 1'b1; hresp = 2'b01;
        @(posedge clk); #1 hresp = 2'b00;
        chk("rvalid_set", axil_rvalid, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rvalid_held", axil_rvalid, 1'b1);
        chk("rdata_held", axil_rdata, 32'hC0DE_0010);
        axil_rready = 1'b1;
        drain();

        // timeout: DECERR exactly 8 cycles after ADDR entry
        hready = 1'b0;
        exp_r(1'b0, 2'b11, 1'b0, 32'h0);
        send_ar(16'h0020);
        chk("hsel_addr_phase", hsel, 1'b1);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (axil_rvalid) break;
        end
        chk("timeout_cycles", cyc, 8);
        chk("timeout_rresp", axil_rresp, 2'b11);
        chk("timeout_hsel", hsel, 1'b0);
        hready = 1'b1;
        drain();

        // reset mid-DATA abandons the read
        exp_x(1'b0, 16'h0030, 3'd2, 32'h0);
        send_ar(16'h0030);
        @(posedge clk); #1 hready = 1'b0;
        chk("data_phase_hsel", hsel, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(posedge clk); #1 rst_n = 1'b1; hready = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_valid = any_valid | axil_bvalid | axil_rvalid;
        end
        chk("no_resp_after_reset", any_valid, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
